fetch_unit: RTL and testbench

Per-core instruction-fetch stage that sits directly upstream of the instruction ROM in the single-cycle manycore MIPS. It owns the program counter, drives the ROM word address, and returns the fetched word to decode. It handles stall, branch/jump redirect, HALT (opcode 63) detection and resume, and holds a sticky alignment-error flag. One instance exists per core.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_perf_ctr.sv | 28 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state type for the per-core instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_F020;  // add $30,$0,$0
  localparam logic [5:0]  OPC_HALT = 6'd63;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 32-bit event counter with synchronous active-high reset.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, stall, redirect, HALT/resume and sticky alignment error.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned CORE_ID     = 0,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  HALT_OPCODE = OPC_HALT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic         fetch_inc, stall_inc;
  logic         is_halt;

  // CORE_ID only labels simulation traces; keep it referenced.
  logic unused_core_id;
  assign unused_core_id = ^CORE_ID;

  assign pc_plus4 = pc_q + PC_STEP;
  assign is_halt  = (imem_data[31:26] == HALT_OPCODE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    fetch_inc = 1'b0;
    stall_inc = 1'b0;
    instr     = imem_data;
    unique case (state_q)
      HALTED: begin
        instr = NOP_WORD;
        if (resume) begin
          pc_d    = pc_plus4;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stall) begin
          stall_inc = 1'b1;
        end else begin
          fetch_inc = 1'b1;
          // A HALT word wins over a same-cycle redirect.
          if (is_halt) begin
            state_d = HALTED;
          end else if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
              err_d = 1'b1;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);
  assign fetch_err = err_q;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_fetch_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_inc),
    .count (fetch_count)
  );

  fetch_perf_ctr u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );
`else
  logic unused_perf;
  assign unused_perf = fetch_inc ^ stall_inc;
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan sequences plus random traffic vs a reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_F020;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, resume;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, instr, pc, pc_plus4;
  logic        halted, fetch_err;
  logic [31:0] fetch_count, stall_count;

  logic [31:0] rom [0:255];

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[9:2]];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .resume      (resume),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        h;
    logic        e;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [31:0] m_pc, m_fc, m_sc;
  logic        m_h, m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("imem_addr", imem_addr, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
      check("instr", instr, e.instr);
      check("halted", {31'd0, halted}, {31'd0, e.h});
      check("fetch_err", {31'd0, fetch_err}, {31'd0, e.e});
      check("fetch_count", fetch_count, e.fc);
      check("stall_count", stall_count, e.sc);
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply one cycle of inputs; push the expected outputs, then advance the model.
  task automatic step(input logic rst, input logic stl, input logic red,
                      input logic [31:0] rpc, input logic res, input bit chk);
    exp_t e;
    logic [31:0] word;
    reset = rst; stall = stl; redirect = red; redirect_pc = rpc; resume = res;
    word = rom[m_pc[9:2]];
    if (chk) begin
      e.pc    = m_pc;
      e.instr = m_h ? NOP : word;
      e.h     = m_h;
      e.e     = m_e;
`ifdef FETCH_PERF_EN
      e.fc    = m_fc;
      e.sc    = m_sc;
`else
      e.fc    = 32'd0;
      e.sc    = 32'd0;
`endif
      exp_q.push_back(e);
    end
    if (rst) begin
      m_pc = 32'd0; m_h = 1'b0; m_e = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    end else if (m_h) begin
      if (res) begin
        m_pc = m_pc + 32'd4;
        m_h  = 1'b0;
      end
    end else if (stl) begin
      m_sc = sat_inc(m_sc);
    end else begin
      m_fc = sat_inc(m_fc);
      if (word[31:26] == 6'd63) begin
        m_h = 1'b1;
      end else if (red) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        if (rpc[1:0] != 2'b00) m_e = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; resume = 1'b0;
    m_pc = 32'd0; m_h = 1'b0; m_e = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = {6'(i % 62), 26'(i * 32'h0001_3579)};
    end
    rom[23] = {6'd63, 26'h000_F020};  // HALT at byte 92

    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Sequential fetch, then redirect 72 -> 60, then stalled redirect dropped at 72
    free(18);
    step(1'b0, 1'b0, 1'b1, 32'd60, 1'b0, 1'b1);
    free(3);
    step(1'b0, 1'b1, 1'b1, 32'd60, 1'b0, 1'b1);
    // Resume in RUN ignored, then run to HALT at 92 and hold 10 cycles
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    free(4);
    free(1);
    for (int i = 0; i < 10; i++) step(1'b0, i[0], i[1], 32'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    free(2);
    // Misaligned redirect: sticky error until reset
    step(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b1);
    free(4);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    free(1);

    // Counters: 5 fetches, 2 stalls, then the HALT cycle
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'd76, 1'b0, 1'b1);
    free(4);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    free(3);
    // Reset while halted
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    free(1);

    // Random traffic with a sprinkling of HALT words
    for (int i = 32; i < 256; i++) begin
      rom[i] = $urandom();
      if ($urandom_range(0, 11) == 0) rom[i][31:26] = 6'd63;
      else if (rom[i][31:26] == 6'd63) rom[i][31:26] = 6'd62;
    end
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                       : 32'($urandom_range(0, 255) * 4),
           $urandom_range(0, 3) == 0, 1'b1);
    end

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
